// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: accepts one load/store at a time,
// waits LATENCY cycles, then commits the access and pulses a one-cycle response.
// stall holds the pipeline from the request cycle until the response arrives.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        stall,
  output logic        addr_err,
  output logic [15:0] T_V
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            stateReg;
  logic [3:0]        cntReg;
  logic              writeReg;
  logic [31:0]       addrReg;
  logic [31:0]       wdataReg;
  logic [31:0]       mem [DEPTH];

  logic              addrLegal;
  logic [IDX_W-1:0]  wordIdx;
  logic              commitNow;
  logic              commitWrite;

  // Address decode of the latched request: word aligned and inside the array.
  always_comb begin
    addrLegal   = (addrReg[1:0] == 2'b00) && ((addrReg >> 2) < 32'(DEPTH));
    wordIdx     = addrReg[IDX_W+1:2];
    commitNow   = (stateReg == WAIT) && (cntReg == 4'd0);
    commitWrite = commitNow && writeReg && addrLegal;
  end

  // Handshake and hazard outputs derived from the current state.
  always_comb begin
    req_ready = (stateReg == IDLE);
    stall     = ((stateReg == IDLE) && req_valid) || (stateReg == WAIT);
    T_V       = mem[0][15:0];
  end

  // Storage array: cleared by reset, written only by a legal store at commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (commitWrite) begin
      mem[wordIdx] <= wdataReg;
    end
  end

  // Request/response FSM with registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg   <= IDLE;
      cntReg     <= 4'd0;
      writeReg   <= 1'b0;
      addrReg    <= '0;
      wdataReg   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      addr_err   <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            writeReg <= req_write;
            addrReg  <= req_addr;
            wdataReg <= req_wdata;
            cntReg   <= 4'(LATENCY - 1);
            stateReg <= WAIT;
          end
        end
        WAIT: begin
          if (cntReg == 4'd0) begin
            // Access happens on this edge; loads sample the array before any update.
            resp_valid <= 1'b1;
            addr_err   <= !addrLegal;
            resp_rdata <= (addrLegal && !writeReg) ? mem[wordIdx] : 32'd0;
            stateReg   <= RESP;
          end else begin
            cntReg <= cntReg - 4'd1;
          end
        end
        RESP: begin
          // Response strobe lasts one cycle; rdata holds, the error flag does not.
          resp_valid <= 1'b0;
          addr_err   <= 1'b0;
          stateReg   <= IDLE;
        end
        default: begin
          stateReg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver predicts each response from an
// array model when a request is accepted; a negedge monitor checks every strobe.
module tb_dmem_responder;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        stall;
  logic        addr_err;
  logic [15:0] T_V;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .stall     (stall),
    .addr_err  (addr_err),
    .T_V       (T_V)
  );

  typedef struct {
    int          cyc;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
    logic [15:0] tv;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon;
  logic [31:0] refMem [DEPTH];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          stallRun = 0;
  int          lastAccept = 0;
  int          prevAccept = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
  endtask

  // Monitor: every response strobe must match the oldest prediction.
  always @(negedge clk) begin
    if (rst) begin
      stallRun = 0;
    end else begin
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          mon = sbq.pop_front();
          check("resp_cycle", 32'(cyc), 32'(mon.cyc));
          check("resp_rdata", resp_rdata, mon.rdata);
          check("addr_err", {31'd0, addr_err}, {31'd0, mon.err});
          check("stall_in_resp", {31'd0, stall}, 32'd0);
          check("ready_in_resp", {31'd0, req_ready}, 32'd0);
          check("stall_cycles", 32'(stallRun), 32'(LATENCY + 1));
          check("T_V", {16'd0, T_V}, {16'd0, mon.tv});
          $display("[TB] %s addr=%h rdata=%h err=%b cycle=%0d", mon.wr ? "store" : "load ",
                   mon.addr, resp_rdata, addr_err, cyc);
        end
      end else if (sbq.size() > 0 && cyc >= sbq[0].cyc) begin
        mon = sbq.pop_front();
        tests++;
        fails++;
        $display("FAIL resp_missing: got no resp_valid expected response for addr %h at cycle %0d",
                 mon.addr, mon.cyc);
      end
      stallRun = stall ? stallRun + 1 : 0;
    end
  end

  // Present a request (valid stays high afterwards) and predict its response on accept.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    bit   accepted = 0;
    bit   legal;
    exp_t x;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (req_ready) begin
        accepted = 1;
        break;
      end
    end
    if (!accepted) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got req_ready=0 for 64 cycles expected accept of addr %h", a);
    end else begin
      legal   = (a % 4 == 0) && (a / 4 < DEPTH);
      x.cyc   = cyc + LATENCY + 1;
      x.wr    = wr;
      x.addr  = a;
      x.err   = !legal;
      x.rdata = (legal && !wr) ? refMem[a / 4] : 32'd0;
      if (legal && wr) refMem[a / 4] = d;
      x.tv    = refMem[0][15:0];
      sbq.push_back(x);
      prevAccept = lastAccept;
      lastAccept = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    req_valid = 1'b0;
    for (int n = 0; n < 100 && sbq.size() > 0; n++) @(negedge clk);
    if (sbq.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sbq.size());
      sbq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] idx;
    clearModel();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_addr_err", {31'd0, addr_err}, 32'd0);
    check("rst_T_V", {16'd0, T_V}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Load from word 0 right after reset, then store/load of 0x10 back to back
    issue(1'b0, 32'h0, 32'h0);
    issue(1'b1, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 32'h10, 32'h0);
    check("b2b_accept_gap", 32'(lastAccept - prevAccept), 32'(LATENCY + 2));
    issue(1'b0, 32'h0, 32'h0);
    check("b2b_accept_gap2", 32'(lastAccept - prevAccept), 32'(LATENCY + 2));
    idle(2);

    // Illegal addresses leave memory untouched
    issue(1'b1, 32'h3, 32'h11111111);
    idle(1);
    issue(1'b1, 32'(4 * DEPTH), 32'h22222222);
    idle(1);
    issue(1'b0, 32'h10, 32'h0);
    issue(1'b0, 32'h0, 32'h0);

    // Word 0 store shows on T_V
    issue(1'b1, 32'h0, 32'h0001ABCD);
    drain();
    check("T_V_after_word0", {16'd0, T_V}, 32'h0000ABCD);

    // Reset during WAIT of a store aborts it
    issue(1'b1, 32'h8, 32'hCAFEF00D);
    req_valid = 1'b0;
    rst = 1'b1;
    sbq.delete();
    clearModel();
    @(negedge clk);
    check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("midrst_T_V", {16'd0, T_V}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (LATENCY + 3) @(negedge clk);
    @(posedge clk);
    #1;
    issue(1'b0, 32'h8, 32'h0);
    idle(1);

    // Randomised traffic with random gaps (gap 0 keeps valid high through RESP)
    for (int t = 0; t < 300; t++) begin
      int gap;
      int kind;
      kind = int'($urandom_range(0, 9));
      idx  = $urandom_range(0, DEPTH - 1);
      case (kind)
        6:       a = idx * 4 + $urandom_range(1, 3);
        7:       a = 32'(4 * DEPTH) + 4 * $urandom_range(0, 7);
        8:       a = $urandom;
        9:       a = 32'(4 * (DEPTH - 1));
        default: a = idx * 4;
      endcase
      gap = int'($urandom_range(0, 3));
      if (gap > 0) idle(gap);
      issue(1'($urandom_range(0, 1)), a, $urandom);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
